// File: rtl/poci_pkg.sv
// poci_pkg: shared types and helpers for the POCI register-file slice.
//   poci_state_e   : serializer FSM state encoding (IDLE, LOAD, SHIFT)
//   BYTE_W         : serial byte width
//   ADDR_UNSET     : address value meaning "pointer unset"
//   STATUS_ADDR_DEFAULT : default read-only status address
//   addr_in_range  : true when addr selects one of n registers starting at base
package poci_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } poci_state_e;

  localparam int         BYTE_W              = 8;
  localparam logic [7:0] ADDR_UNSET          = 8'h00;
  localparam logic [7:0] STATUS_ADDR_DEFAULT = 8'hFF;

  // Address 0 never matches, even if a caller passes base 0.
  function automatic logic addr_in_range(input logic [7:0] addr, input int base, input int n);
    int a;
    a = int'({24'd0, addr});
    return (addr != ADDR_UNSET) && (a >= base) && (a < base + n);
  endfunction

endpackage

// File: rtl/poci_shifter.sv
// poci_shifter: byte serializer for POCI, MSB first, one byte per 8 sclk edges.
// Ports:
//   sclk      in   serial clock
//   rstn      in   async active-low reset
//   txn_clr   in   sync transaction clear; returns to IDLE, clears bit_cnt/shifter
//   load_data in 8 byte captured on the LOAD edge
//   poci      out  serial data (shifter MSB)
//   byte_done out  one-cycle pulse while bit 0 of a byte is on poci
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; leaves on the first edge without txn_clr
// LOAD  | bit_cnt == 0; this edge captures load_data, MSB goes out
// SHIFT | bits 6..0 shifted out; bit_cnt == 7 edge drives bit 0
module poci_shifter
  import poci_pkg::*;
(
  input  logic              sclk,
  input  logic              rstn,
  input  logic              txn_clr,
  input  logic [BYTE_W-1:0] load_data,
  output logic              poci,
  output logic              byte_done
);

  poci_state_e       state, state_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0] shifter, shifter_nxt;
  logic              byte_done_nxt;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shifter   <= '0;
      byte_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shifter   <= shifter_nxt;
      byte_done <= byte_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shifter_nxt   = shifter;
    byte_done_nxt = 1'b0;
    if (txn_clr) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 3'd0;
      shifter_nxt = '0;
    end else begin
      case (state)
        IDLE: state_nxt = LOAD;
        LOAD: begin
          shifter_nxt = load_data;
          bit_cnt_nxt = 3'd1;
          state_nxt   = SHIFT;
        end
        SHIFT: begin
          shifter_nxt = {shifter[BYTE_W-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 3'd1;  // wraps 7 -> 0 for the next LOAD
          if (bit_cnt == 3'd7) begin
            state_nxt     = LOAD;
            byte_done_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // MSB of the shifter register is the line, so an async reset drops poci at once.
  assign poci = shifter[BYTE_W-1];

endmodule

// File: rtl/poci_regfile.sv
// poci_regfile: write/read register bank with POCI serial readback.
// Ports:
//   sclk       in   serial clock (only clock)
//   rstn       in   async active-low reset; the only thing that clears registers
//   txn_clr    in   sync transaction clear for the serializer
//   wr_stb     in   one-cycle write strobe
//   wr_addr    in 8 write address (valid with wr_stb)
//   wr_data    in 8 write data (valid with wr_stb)
//   rd_addr    in 8 address serialized at each byte load
//   poci       out  serial read data, MSB first
//   byte_done  out  pulse while bit 0 of a byte is driven
//   reg_out    out  flat register contents, reg[i] at [8i+7:8i]
//   wr_count   out 8 count of committed writes (wraps)
// Build option: define POCI_WR_LOCK_EN to make reg[NUM_REGS-1] bit 7 a write
// lock for all other registers and to report it in the status byte MSB.
module poci_regfile
  import poci_pkg::*;
#(
  parameter int         NUM_REGS    = 16,
  parameter int         BASE_ADDR   = 1,
  parameter logic [7:0] STATUS_ADDR = STATUS_ADDR_DEFAULT,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic                       sclk,
  input  logic                       rstn,
  input  logic                       txn_clr,
  input  logic                       wr_stb,
  input  logic [7:0]                 wr_addr,
  input  logic [BYTE_W-1:0]          wr_data,
  input  logic [7:0]                 rd_addr,
  output logic                       poci,
  output logic                       byte_done,
  output logic [NUM_REGS*BYTE_W-1:0] reg_out,
  output logic [7:0]                 wr_count
);

  logic [BYTE_W-1:0] regs [NUM_REGS];
  logic [7:0]        wr_idx, rd_idx;
  logic              wr_hit, rd_hit, wr_ok;
  logic [BYTE_W-1:0] status_byte, rd_val, load_data;

  assign wr_idx = wr_addr - 8'(BASE_ADDR);
  assign rd_idx = rd_addr - 8'(BASE_ADDR);
  assign wr_hit = addr_in_range(wr_addr, BASE_ADDR, NUM_REGS);
  assign rd_hit = addr_in_range(rd_addr, BASE_ADDR, NUM_REGS);

`ifdef POCI_WR_LOCK_EN
  logic lock;
  assign lock        = regs[NUM_REGS-1][BYTE_W-1];
  // The lock register itself stays writable so software can unlock.
  assign wr_ok       = wr_hit && (!lock || (wr_idx == 8'(NUM_REGS-1)));
  assign status_byte = {lock, wr_count[6:0]};
`else
  assign wr_ok       = wr_hit;
  assign status_byte = wr_count;
`endif

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (wr_stb && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == 8'(i)) regs[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) wr_count <= 8'd0;
    else if (wr_stb && wr_ok) wr_count <= wr_count + 8'd1;
  end

  always_comb begin
    rd_val = '0;
    if (rd_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_idx == 8'(i)) rd_val = regs[i];
      end
    end else if (rd_addr == STATUS_ADDR) begin
      rd_val = status_byte;
    end
  end

  // Write-through: a byte loaded on the same edge as a committing write to
  // the same address must carry the new data, not the stale register.
  assign load_data = (wr_stb && wr_ok && (wr_addr == rd_addr)) ? wr_data : rd_val;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_out[g*BYTE_W +: BYTE_W] = regs[g];
  end

  poci_shifter u_shifter (
    .sclk      (sclk),
    .rstn      (rstn),
    .txn_clr   (txn_clr),
    .load_data (load_data),
    .poci      (poci),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_poci_regfile.sv
module tb_poci_regfile;

  logic         sclk;
  logic         rstn;
  logic         txn_clr;
  logic         wr_stb;
  logic [7:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [7:0]   rd_addr;
  logic         poci;
  logic         byte_done;
  logic [127:0] reg_out;
  logic [7:0]   wr_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_regs [16];
  logic [7:0] m_cnt;
  logic [7:0] exp_q [$];
  logic [7:0] sr;
  logic [7:0] mon_e;

  poci_regfile dut (
    .sclk      (sclk),
    .rstn      (rstn),
    .txn_clr   (txn_clr),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .poci      (poci),
    .byte_done (byte_done),
    .reg_out   (reg_out),
    .wr_count  (wr_count)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_commit(input logic [7:0] a);
    bit ok;
    ok = (a >= 8'h01) && (a <= 8'h10);
`ifdef POCI_WR_LOCK_EN
    if (m_regs[15][7] && a != 8'h10) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [7:0] m_sel(input logic [7:0] a);
    int idx;
    idx = int'({24'd0, a}) - 1;
    if (a >= 8'h01 && a <= 8'h10) return m_regs[idx];
`ifdef POCI_WR_LOCK_EN
    if (a == 8'hFF) return {m_regs[15][7], m_cnt[6:0]};
`else
    if (a == 8'hFF) return m_cnt;
`endif
    return 8'h00;
  endfunction

  function automatic logic [127:0] m_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    int idx;
    idx = int'({24'd0, a}) - 1;
    if (m_commit(a)) begin
      m_regs[idx] = d;
      m_cnt       = m_cnt + 8'd1;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_cnt = 8'h00;
  endtask

  // ---------------- output monitor ----------------
  always @(negedge sclk) begin
    sr = {sr[6:0], poci};
    if (byte_done) begin
      if (exp_q.size() == 0) begin
        check("byte_unexpected", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("byte", sr, mon_e);
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  // Writes happen while txn_clr is held high, so they also cover write+clear.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge sclk); #1;
    wr_addr = a; wr_data = d; wr_stb = 1'b1;
    @(posedge sclk); #1;
    wr_stb = 1'b0;
    m_write(a, d);
    check("wr_regs", reg_out, m_flat());
    check("wr_cnt", wr_count, m_cnt);
  endtask

  // Runs exactly one byte from IDLE; optional write on the LOAD edge and an
  // optional rd_addr change mid-byte.
  task automatic read_byte(input logic [7:0] addr, input bit do_wr = 1'b0,
                           input logic [7:0] wa = 8'h00, input logic [7:0] wd = 8'h00,
                           input bit chg = 1'b0);
    logic [7:0] e;
    e = m_sel(addr);
    if (do_wr && m_commit(wa) && wa == addr) e = wd;
    exp_q.push_back(e);
    rd_addr = addr; txn_clr = 1'b0;
    @(posedge sclk); #1;              // IDLE -> LOAD
    if (do_wr) begin wr_addr = wa; wr_data = wd; wr_stb = 1'b1; end
    @(posedge sclk); #1;              // LOAD edge: bit 7 out
    if (do_wr) begin wr_stb = 1'b0; m_write(wa, wd); end
    check("bit7", poci, e[7]);
    for (int k = 1; k <= 6; k++) begin
      @(posedge sclk); #1;
      if (chg && k == 2) rd_addr = 8'h03;
    end
    @(posedge sclk); #1;              // 8th edge: bit 0
    check("done_on_8th", byte_done, 1'b1);
    txn_clr = 1'b1;
    @(posedge sclk); #1;
    check("q_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] e;
    sr = 8'h00;
    rstn = 1'b0; txn_clr = 1'b1; wr_stb = 1'b0;
    wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00;
    m_reset();
    repeat (2) @(posedge sclk);
    #1 rstn = 1'b1;
    @(posedge sclk); #1;
    check("rst_regs", reg_out, 128'd0);
    check("rst_poci", poci, 1'b0);
    check("rst_cnt", wr_count, 8'd0);
    check("rst_done", byte_done, 1'b0);

    do_write(8'h03, 8'hA5);
    read_byte(8'h03);

    do_write(8'h01, 8'h11);
    do_write(8'h10, 8'hEE);
    do_write(8'h00, 8'h77);
    do_write(8'h20, 8'h99);
    do_write(8'hFF, 8'h44);
    do_write(8'h11, 8'h66);

    read_byte(8'h20);
    read_byte(8'hFF);
    read_byte(8'h00);
    read_byte(8'h01);
    read_byte(8'h10);

    read_byte(8'h05, 1'b1, 8'h05, 8'h3C);
    read_byte(8'h03, 1'b1, 8'h04, 8'hC3);
    read_byte(8'h01, 1'b0, 8'h00, 8'h00, 1'b1);

    // clear mid-byte after three bits
    e = m_sel(8'h03);
    rd_addr = 8'h03; txn_clr = 1'b0;
    repeat (4) begin @(posedge sclk); #1; end
    check("clr_pre_bit5", poci, e[5]);
    txn_clr = 1'b1;
    @(posedge sclk); #1;
    check("clr_poci", poci, 1'b0);
    check("clr_regs_kept", reg_out, m_flat());
    read_byte(8'h03);

    // wr_count wrap
    for (int i = 0; i < 255; i++) do_write(8'h02, 8'(i));
    read_byte(8'hFF);

    // lock register (ordinary register when the lock build option is off)
    do_write(8'h10, 8'h80);
    do_write(8'h02, 8'h55);
    read_byte(8'hFF);
    do_write(8'h10, 8'h00);
    do_write(8'h02, 8'h55);
    read_byte(8'hFF);
    read_byte(8'h02);

    // async reset mid-byte with registers loaded
    do_write(8'h03, 8'hA5);
    rd_addr = 8'h03; txn_clr = 1'b0;
    repeat (4) begin @(posedge sclk); #1; end
    check("rstmid_pre", poci, 1'b1);
    rstn = 1'b0; txn_clr = 1'b1;
    #1;
    m_reset();
    check("rstmid_poci", poci, 1'b0);
    check("rstmid_regs", reg_out, 128'd0);
    check("rstmid_cnt", wr_count, 8'd0);
    @(posedge sclk); #1;
    rstn = 1'b1;
    @(posedge sclk); #1;
    read_byte(8'h03);
    do_write(8'h0C, 8'h5A);
    read_byte(8'h0C);

    repeat (2) @(posedge sclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poci_regfile.md
Name: poci_regfile

Overview:
- Downstream stage of the PICO byte path, clocked by sclk.
- Holds the chip's digital write/read register bank. Writes are committed from the byte strobe, data and address pointer produced upstream.
- Serializes the register selected by the current address pointer onto POCI, MSB first, one byte per 8 sclk cycles.
- Register contents survive transaction resets; only rstn clears them.

Parameters:
- NUM_REGS, 16, number of 8-bit registers, legal range 1..254.
- BASE_ADDR, 1, address of reg[0]. Address 0 is reserved as "pointer unset".
- STATUS_ADDR, 8'hFF, read-only status address; must lie outside BASE_ADDR..BASE_ADDR+NUM_REGS-1.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- sclk  in  1  SPI clock; the only clock.
- rstn  in  1  asynchronous active-low reset.
- txn_clr  in  1  synchronous transaction clear (asserted high for ≥1 sclk when the transaction stops). Clears bit counter and shifter only.
- wr_stb  in  1  one-sclk-cycle write strobe.
- wr_addr  in  8  write address, valid with wr_stb.
- wr_data  in  8  write data, valid with wr_stb.
- rd_addr  in  8  address to serialize; sampled at each byte load.
- poci  out  1  serial read data.
- byte_done  out  1  high for one cycle when bit 0 of a byte has been driven.
- reg_out  out  NUM_REGS*8  flat register contents; reg[i] is at bits [8i+7:8i].
- wr_count  out  8  count of committed writes.

Behaviour:
- Reset (rstn low, async):
  - All registers = RESET_VAL.
  - Shifter = 0, bit_cnt = 0, wr_count = 0.
  - poci = 0, byte_done = 0, state = IDLE.
- FSM states:
  - IDLE → LOAD on the first sclk edge with txn_clr = 0.
  - LOAD: bit_cnt == 0. Shifter <= sel(rd_addr), bit_cnt <= 1, go to SHIFT.
  - SHIFT: shifter <= shifter << 1, bit_cnt <= bit_cnt + 1. When bit_cnt == 7, assert byte_done next cycle and go to LOAD.
  - txn_clr = 1 in any state: next state IDLE, bit_cnt = 0, shifter = 0. txn_clr has priority over load/shift.
- poci = shifter[7], registered. The first bit of a byte appears one edge after LOAD; the byte occupies exactly 8 consecutive edges.
- sel(a):
  - reg[a-BASE_ADDR] if a is in range.
  - {wr_count} if a == STATUS_ADDR.
  - 8'h00 otherwise, including a == 0.
- Write commit: on an edge with wr_stb = 1 and wr_addr in range, reg[wr_addr-BASE_ADDR] <= wr_data and wr_count increments (wraps 255 → 0).
- Writes not committed (registers and wr_count unchanged):
  - STATUS_ADDR or any out-of-range address: ignored.
  - Address 0: ignored.
- Simultaneous write and load to the same address: the shifter loads wr_data (write-through bypass), never the stale value.
- wr_stb and txn_clr in the same cycle: the write still commits.
- rd_addr changes mid-byte have no effect until the next LOAD.
- rstn mid-byte: poci goes to 0 immediately. The next byte starts from IDLE.

Optional Feature:
- Macro: POCI_WR_LOCK_EN.
- When defined:
  - reg[NUM_REGS-1] bit 7 is a lock bit.
  - While the lock bit is 1, writes to every other register are ignored and do not increment wr_count.
  - Writes to reg[NUM_REGS-1] itself always commit, so software can unlock.
  - sel(STATUS_ADDR) returns {lock, wr_count[6:0]}.
- When undefined: no lock. reg[NUM_REGS-1] is an ordinary register and STATUS_ADDR returns the full wr_count.

Decomposition:
- Package poci_pkg:
  - state enum (IDLE, LOAD, SHIFT).
  - Localparams for byte width 8, address 0 = unset, and default STATUS_ADDR.
  - Function addr_in_range(addr, base, n).
- Sub-module poci_shifter: FSM, bit_cnt, shifter, poci, byte_done. Takes load_data from the parent.
- Parent holds the register bank, write decode, bypass mux and wr_count.

Test Plan:
- Reset: rstn low with registers preloaded → all reg_out = 0, poci = 0, wr_count = 0.
- Write then read: wr_stb with addr 8'h03, data 8'hA5; then rd_addr = 8'h03 → poci = 1,0,1,0,0,1,0,1 over 8 edges, byte_done on the 8th, wr_count = 1.
- Out-of-range writes: addr 8'h00, 8'h20 and 8'hFF → no register change, wr_count unchanged. A read of 8'h20 shifts 8'h00.
- Bypass: wr_stb to addr 8'h05 with data 8'h3C on the LOAD edge while rd_addr = 8'h05 → serialized byte is 8'h3C.
- Clear mid-byte: txn_clr after 3 bits → poci = 0 next edge. The next byte restarts from bit 7, and register contents are retained.
- POCI_WR_LOCK_EN:
  - Write 8'h80 to addr 8'h10 → lock set.
  - Write 8'h55 to 8'h02 → ignored.
  - Write 8'h00 to 8'h10, then 8'h55 to 8'h02 → committed; STATUS read shows lock = 0.
